// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: requests one word per PC value, hands it to the decoder, paces the PC.
// Optional memory timeout with sticky error flag is compiled in with `define FETCH_TIMEOUT_EN.
module instr_fetch #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] pc_addr,
    output logic        pc_inc,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        flush,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        SETTLE = 2'd3
    } state_t;

    state_t      state_reg;
    logic        pc_inc_reg;
    logic        mem_req_reg;
    logic [15:0] mem_addr_reg;
    logic [15:0] ir_out_reg;
    logic        ir_valid_reg;

    // timeout_hit: REQ is being abandoned this edge; err_stop: parked in IDLE until reset
    logic        timeout_hit;
    logic        err_stop;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES : 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeout_cnt_reg;
    logic             fetch_err_reg;

    assign timeout_hit = (state_reg == REQ) && !mem_ack && !flush &&
                         (timeout_cnt_reg == CNT_LAST);
    assign err_stop    = fetch_err_reg;
    assign fetch_err   = fetch_err_reg;

    // Counter sits at zero outside REQ, so every REQ entry starts a fresh count.
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_cnt_reg <= '0;
            fetch_err_reg   <= 1'b0;
        end else begin
            if (state_reg != REQ) begin
                timeout_cnt_reg <= '0;
            end else if (timeout_cnt_reg != CNT_LAST) begin
                timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            end
            if (timeout_hit) begin
                fetch_err_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign err_stop           = 1'b0;
    assign fetch_err          = 1'b0;
`endif

    // ir_valid rises one cycle after the capture edge; together with SETTLE this
    // keeps the next pc_addr latch three cycles behind the pc_inc pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_inc_reg   <= 1'b0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= 16'h0000;
            ir_out_reg   <= 16'h0000;
            ir_valid_reg <= 1'b0;
        end else begin
            pc_inc_reg <= 1'b0;
            if (flush && !err_stop) begin
                state_reg    <= SETTLE;
                mem_req_reg  <= 1'b0;
                ir_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (!err_stop) begin
                            state_reg    <= REQ;
                            mem_addr_reg <= pc_addr;
                            mem_req_reg  <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (mem_ack) begin
                            ir_out_reg  <= mem_rdata;
                            pc_inc_reg  <= 1'b1;
                            mem_req_reg <= 1'b0;
                            state_reg   <= HOLD;
                        end else if (timeout_hit) begin
                            mem_req_reg <= 1'b0;
                            state_reg   <= IDLE;
                        end
                    end
                    HOLD: begin
                        if (!ir_valid_reg) begin
                            ir_valid_reg <= 1'b1;
                        end else if (ir_ready) begin
                            ir_valid_reg <= 1'b0;
                            state_reg    <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        state_reg    <= REQ;
                        mem_addr_reg <= pc_addr;
                        mem_req_reg  <= 1'b1;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pc_inc   = pc_inc_reg;
    assign mem_req  = mem_req_reg;
    assign mem_addr = mem_addr_reg;
    assign ir_out   = ir_out_reg;
    assign ir_valid = ir_valid_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table of fetches plus hand-written flush/reset/wrap/timeout sequences.
// Includes a two-stage PC model so the pc_inc to pc_addr latch spacing is exercised.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] pc_addr;
    logic        pc_inc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        flush;
    logic        fetch_err;

    always #5 clock = ~clock;

    instr_fetch #(.TIMEOUT_CYCLES(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .pc_addr   (pc_addr),
        .pc_inc    (pc_inc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_out    (ir_out),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .flush     (flush),
        .fetch_err (fetch_err)
    );

    // Program counter with a two-stage update: pc_inc -> pending -> pc_addr+1.
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        pc_pend;
    always @(posedge clock) begin
        if (pc_load) begin
            pc_addr <= pc_load_val;
            pc_pend <= 1'b0;
        end else begin
            pc_pend <= pc_inc;
            if (pc_pend) pc_addr <= pc_addr + 16'd1;
        end
    end

    int pc_inc_cnt = 0;
    always @(posedge clock) if (pc_inc === 1'b1) pc_inc_cnt <= pc_inc_cnt + 1;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic        redirect;
        logic [15:0] addr;
        logic [15:0] data;
        int          waits;
        int          rdelay;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task step;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req;
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", {31'd0, mem_req}, 32'd1);
    endtask

    task automatic do_fetch(input logic [15:0] exp_addr, input logic [15:0] data,
                            input int waits, input int rdelay);
        int c0;
        logic [15:0] exp_ir;
        c0 = pc_inc_cnt;
        wait_req();
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
        for (int i = 0; i < waits; i++) begin
            step();
            chk("req_steady", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, exp_addr});
        end
        mem_ack   = 1'b1;
        mem_rdata = data;
        sb_q.push_back(data);
        ir_ready  = (rdelay == 0);
        step();
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        chk("inc_pulse", {29'd0, pc_inc, mem_req, ir_valid}, {29'd0, 3'b100});
        step();
        chk("inc_once_valid", {30'd0, pc_inc, ir_valid}, {30'd0, 2'b01});
        if (sb_q.size() == 0) begin
            exp_ir = 16'h0000;
            n_vec++;
            n_bad++;
            $display("FAIL sb_empty: got ir_out %h, want a queued word", ir_out);
        end else begin
            exp_ir = sb_q.pop_front();
            chk("ir_out", {16'd0, ir_out}, {16'd0, exp_ir});
        end
        for (int i = 0; i < rdelay; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = ~data;
            step();
            chk("hold_stable", {15'd0, ir_valid, ir_out}, {15'd0, 1'b1, exp_ir});
        end
        mem_ack  = 1'b0;
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        chk("valid_clear", {31'd0, ir_valid}, 32'd0);
        chk("inc_count", pc_inc_cnt - c0, 32'd1);
        $display("fetch addr=%h data=%h waits=%0d hold=%0d ir_out=%h", exp_addr, data, waits, rdelay, ir_out);
    endtask

    task automatic redirect(input logic [15:0] addr);
        flush       = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = addr;
        step();
        flush   = 1'b0;
        pc_load = 1'b0;
        chk("redirect_req_low", {31'd0, mem_req}, 32'd0);
        $display("redirect pc=%h", addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        vecs[0] = '{1'b0, 16'h0001, 16'hA5C3, 0, 0};
        vecs[1] = '{1'b0, 16'h0002, 16'h1234, 3, 5};
        vecs[2] = '{1'b0, 16'h0003, 16'hFFFF, 1, 0};
        vecs[3] = '{1'b0, 16'h0004, 16'h0000, 0, 2};
        vecs[4] = '{1'b1, 16'hFFFF, 16'h5A5A, 2, 1};
        vecs[5] = '{1'b0, 16'h0000, 16'h0F0F, 0, 0};
        vecs[6] = '{1'b0, 16'h0001, 16'h8001, 0, 0};

        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0000; ir_ready = 1'b0; flush = 1'b0;
        pc_load = 1'b1; pc_load_val = 16'h0001;
        step();
        step();
        pc_load = 1'b0;
        chk("reset_outs", {9'd0, mem_req, mem_addr, ir_out[4:0], ir_valid, pc_inc, fetch_err},
            32'd0);
        chk("reset_ir_out", {16'd0, ir_out}, 32'd0);
        reset = 1'b0;
        step();
        chk("idle_to_req", {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0001});
        $display("reset released, first request addr=%h", mem_addr);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].redirect) redirect(vecs[i].addr);
            do_fetch(vecs[i].addr, vecs[i].data, vecs[i].waits, vecs[i].rdelay);
        end

        // flush coincident with mem_ack: word dropped, PC reloaded to 0x0040
        c0 = pc_inc_cnt;
        wait_req();
        chk("fa_addr", {16'd0, mem_addr}, 32'h0002);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; flush = 1'b1;
        pc_load = 1'b1; pc_load_val = 16'h0040;
        step();
        mem_ack = 1'b0; flush = 1'b0; pc_load = 1'b0;
        chk("fa_outs", {29'd0, mem_req, ir_valid, pc_inc}, 32'd0);
        step();
        chk("fa_no_valid", {30'd0, ir_valid, pc_inc}, 32'd0);
        chk("fa_no_inc", pc_inc_cnt - c0, 32'd0);
        $display("flush+ack dropped word BEEF, inc=%0d", pc_inc_cnt - c0);
        do_fetch(16'h0040, 16'hC0DE, 0, 0);

        // flush coincident with ir_ready: treated as flush, PC reloaded to 0x0100
        c0 = pc_inc_cnt;
        wait_req();
        chk("fr_addr", {16'd0, mem_addr}, 32'h0041);
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        step();
        chk("fr_valid", {15'd0, ir_valid, ir_out}, {15'd0, 1'b1, 16'h7777});
        flush = 1'b1; ir_ready = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0100;
        step();
        flush = 1'b0; ir_ready = 1'b0; pc_load = 1'b0;
        chk("fr_clear", {30'd0, ir_valid, mem_req}, 32'd0);
        chk("fr_inc", pc_inc_cnt - c0, 32'd1);
        $display("flush+ready consumed 7777, redirect to 0100");
        do_fetch(16'h0100, 16'h4242, 1, 1);

        // reset on the second REQ cycle, then a stray ack while IDLE
        c0 = pc_inc_cnt;
        wait_req();
        step();
        chk("rst_in_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; pc_load = 1'b1; pc_load_val = 16'h0200;
        step();
        chk("rst_outs", {12'd0, mem_req, mem_addr, ir_valid, pc_inc, fetch_err}, 32'd0);
        chk("rst_ir_out", {16'd0, ir_out}, 32'd0);
        reset = 1'b0; pc_load = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h9999;
        step();
        mem_ack = 1'b0;
        chk("rst_stray", {13'd0, mem_req, ir_valid, pc_inc, ir_out}, {13'd0, 3'b100, 16'h0000});
        chk("rst_addr", {16'd0, mem_addr}, 32'h0200);
        step();
        chk("rst_stray2", {29'd0, mem_req, ir_valid, pc_inc}, {29'd0, 3'b100});
        chk("rst_no_inc", pc_inc_cnt - c0, 32'd0);
        $display("reset mid-request abandoned, stray ack ignored");
        do_fetch(16'h0200, 16'h3C3C, 0, 0);

`ifdef FETCH_TIMEOUT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_req();
        for (int i = 1; i < 16; i++) begin
            step();
            chk("to_wait", {30'd0, fetch_err, mem_req}, {30'd0, 2'b01});
        end
        step();
        chk("to_err", {30'd0, fetch_err, mem_req}, {30'd0, 2'b10});
        c0 = pc_inc_cnt;
        for (int i = 0; i < 4; i++) begin
            flush = (i == 1);
            step();
            chk("to_parked", {29'd0, fetch_err, mem_req, pc_inc}, {29'd0, 3'b100});
        end
        flush = 1'b0;
        chk("to_no_inc", pc_inc_cnt - c0, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("to_reset", {31'd0, fetch_err}, 32'd0);
        $display("timeout raised fetch_err and parked in IDLE");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
